mcm_angular_pipe: RTL and testbench

- Parametrised, pipelined multiple-constant-multiplier (MCM) for VVC intra angular 2-tap interpolation.
- Each beat carries LANES+1 reference samples and one 5-bit fractional position f. Each lane computes ((32−f)·ref[i] + f·ref[i+1] + 16) >> 5.
- Constant products use shift-add trees only; no generic multipliers are inferred.
- Sits between the reference-sample fetch unit and the prediction writeback, with valid/ready handshakes on both sides.

---
 rtl/mcm_angular_pipe.sv | 127 ++++++++++++
 tb/tb_mcm_angular_pipe.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcm_angular_pipe.sv
// Two-stage shift-add MCM for VVC angular 2-tap interpolation with valid/ready flow control.
// Optional debug port out_prod is enabled by defining MCM_PROD_OUT_EN.
module mcm_angular_pipe #(
   parameter int unsigned BIT_DEPTH = 8,
   parameter int unsigned LANES     = 4,
   parameter int unsigned FRAC_BITS = 5
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [(LANES+1)*BIT_DEPTH-1:0]   in_ref,
   input  logic [FRAC_BITS-1:0]             in_frac,
   input  logic                             in_last,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [LANES*BIT_DEPTH-1:0]       out_pred,
   output logic                             out_last,
   output logic [7:0]                       out_row
`ifdef MCM_PROD_OUT_EN
   ,
   output logic [2*LANES*(BIT_DEPTH+6)-1:0] out_prod
`endif
);

   localparam int unsigned PW = BIT_DEPTH + 6;

   logic                              w_ready2;
   logic                              w_accept;
   logic [5:0]                        w_w0;
   logic [5:0]                        w_w1;
   logic [LANES-1:0][PW-1:0]          w_p0;
   logic [LANES-1:0][PW-1:0]          w_p1;
   logic [LANES-1:0][PW-1:0]          w_sum;
   logic [LANES-1:0][BIT_DEPTH-1:0]   w_pred;

   logic                              r_v1;
   logic                              r_v2;
   logic [LANES-1:0][PW-1:0]          r_p0;
   logic [LANES-1:0][PW-1:0]          r_p1;
   logic                              r_last1;
   logic                              r_last2;
   logic [7:0]                        r_row1;
   logic [7:0]                        r_row2;
   logic [7:0]                        r_row_cnt;
   logic [LANES-1:0][BIT_DEPTH-1:0]   r_pred;
`ifdef MCM_PROD_OUT_EN
   logic [LANES-1:0][2*PW-1:0]        r_prod;
`endif

   // Weight is at most 32, so six partial products cover every case.
   function automatic logic [PW-1:0] shift_add(input logic [BIT_DEPTH-1:0] s,
                                               input logic [5:0] w);
      logic [PW-1:0] acc;
      acc = '0;
      for (int b = 0; b < 6; b++) begin
         if (w[b]) acc = acc + (PW'(s) << b);
      end
      return acc;
   endfunction

   assign w_ready2 = !r_v2 || out_ready;
   assign in_ready = !r_v1 || w_ready2;
   assign w_accept = in_valid && in_ready;
   assign w_w1     = 6'(in_frac);
   assign w_w0     = 6'd32 - w_w1;

   always_comb begin
      w_p0   = '0;
      w_p1   = '0;
      w_sum  = '0;
      w_pred = '0;
      for (int i = 0; i < LANES; i++) begin
         w_p0[i]   = shift_add(in_ref[i*BIT_DEPTH +: BIT_DEPTH], w_w0);
         w_p1[i]   = shift_add(in_ref[(i+1)*BIT_DEPTH +: BIT_DEPTH], w_w1);
         w_sum[i]  = r_p0[i] + r_p1[i] + PW'(16);
         w_pred[i] = BIT_DEPTH'(w_sum[i] >> 5);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_v1      <= 1'b0;
         r_v2      <= 1'b0;
         r_p0      <= '0;
         r_p1      <= '0;
         r_last1   <= 1'b0;
         r_last2   <= 1'b0;
         r_row1    <= '0;
         r_row2    <= '0;
         r_row_cnt <= '0;
         r_pred    <= '0;
`ifdef MCM_PROD_OUT_EN
         r_prod    <= '0;
`endif
      end else begin
         if (in_ready) r_v1 <= in_valid;
         if (w_accept) begin
            r_p0      <= w_p0;
            r_p1      <= w_p1;
            r_last1   <= in_last;
            r_row1    <= r_row_cnt;
            r_row_cnt <= in_last ? 8'd0 : r_row_cnt + 8'd1;
         end
         if (w_ready2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
               r_pred  <= w_pred;
               r_last2 <= r_last1;
               r_row2  <= r_row1;
`ifdef MCM_PROD_OUT_EN
               for (int i = 0; i < LANES; i++) r_prod[i] <= {r_p1[i], r_p0[i]};
`endif
            end
         end
      end
   end

   assign out_valid = r_v2;
   assign out_pred  = r_pred;
   assign out_last  = r_last2;
   assign out_row   = r_row2;
`ifdef MCM_PROD_OUT_EN
   assign out_prod  = r_prod;
`endif

endmodule

// File: tb/tb_mcm_angular_pipe.sv
// Scoreboard bench for mcm_angular_pipe (BIT_DEPTH=8, LANES=4); checks out_prod when
// MCM_PROD_OUT_EN is defined.
module tb_mcm_angular_pipe;

   localparam int unsigned BD = 8;
   localparam int unsigned LN = 4;
   localparam int unsigned PW = BD + 6;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic                  in_valid = 1'b0;
   logic                  in_ready;
   logic [(LN+1)*BD-1:0]  in_ref = '0;
   logic [4:0]            in_frac = '0;
   logic                  in_last = 1'b0;
   logic                  out_valid;
   logic                  out_ready = 1'b1;
   logic [LN*BD-1:0]      out_pred;
   logic                  out_last;
   logic [7:0]            out_row;
`ifdef MCM_PROD_OUT_EN
   logic [2*LN*PW-1:0]    out_prod;
`endif

   mcm_angular_pipe #(
      .BIT_DEPTH (BD),
      .LANES     (LN),
      .FRAC_BITS (5)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_ref    (in_ref),
      .in_frac   (in_frac),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_pred  (out_pred),
      .out_last  (out_last),
      .out_row   (out_row)
`ifdef MCM_PROD_OUT_EN
      ,
      .out_prod  (out_prod)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [LN*BD-1:0]   pred;
      logic               last;
      logic [7:0]         row;
      logic [2*LN*PW-1:0] prod;
   } exp_t;

   exp_t             sb[$];
   exp_t             e_push;
   exp_t             e_pop;
   int               n_checks = 0;
   int               n_err = 0;
   logic [7:0]       m_row = '0;
   logic             acc_seen = 1'b0;
   logic             prev_stall = 1'b0;
   logic [LN*BD-1:0] prev_pred = '0;
   int               ma, mb, mf, mp0, mp1;

   task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Inputs change only just after a rising edge, so the falling edge sees exactly what the
   // next rising edge will act on.
   always @(negedge clk) begin
      if (!rst_n) begin
         acc_seen   = 1'b0;
         prev_stall = 1'b0;
         m_row      = '0;
         sb.delete();
      end else begin
         acc_seen = in_valid && in_ready;
         if (acc_seen) begin
            e_push.pred = '0;
            e_push.prod = '0;
            mf = int'(in_frac);
            for (int i = 0; i < LN; i++) begin
               ma  = int'(in_ref[i*BD +: BD]);
               mb  = int'(in_ref[(i+1)*BD +: BD]);
               mp0 = (32 - mf) * ma;
               mp1 = mf * mb;
               e_push.pred[i*BD +: BD]        = BD'((mp0 + mp1 + 16) / 32);
               e_push.prod[i*2*PW +: PW]      = PW'(mp0);
               e_push.prod[i*2*PW + PW +: PW] = PW'(mp1);
            end
            e_push.last = in_last;
            e_push.row  = m_row;
            sb.push_back(e_push);
            m_row = in_last ? 8'd0 : m_row + 8'd1;
         end
         if (prev_stall && out_valid) check_eq("stall_hold", out_pred, prev_pred);
         if (out_valid && out_ready) begin
            check_eq("sb_nonempty", 128'(sb.size() > 0), 128'(1));
            if (sb.size() > 0) begin
               e_pop = sb.pop_front();
               check_eq("pred", out_pred, e_pop.pred);
               check_eq("last", out_last, e_pop.last);
               check_eq("row", out_row, e_pop.row);
`ifdef MCM_PROD_OUT_EN
               check_eq("prod", out_prod, e_pop.prod);
`endif
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_pred  = out_pred;
      end
   end

   function automatic logic [(LN+1)*BD-1:0] pack5(input int r0, input int r1, input int r2,
                                                  input int r3, input int r4);
      return {BD'(r4), BD'(r3), BD'(r2), BD'(r1), BD'(r0)};
   endfunction

   // Called at posedge+1; returns at posedge+1 after the accepting edge, in_valid still high.
   task automatic send(input logic [(LN+1)*BD-1:0] r, input logic [4:0] f, input logic l);
      int waited;
      waited   = 0;
      in_valid = 1'b1;
      in_ref   = r;
      in_frac  = f;
      in_last  = l;
      do begin
         @(posedge clk);
         waited++;
      end while (!acc_seen && waited < 200);
      check_eq("send_accept", 128'(acc_seen), 128'(1));
      #1;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic lane0_case(input string tag, input int r0, input int r1, input logic [4:0] f,
                             input logic [7:0] exp);
      send(pack5(r0, r1, 0, 0, 0), f, 1'b1);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      check_eq(tag, out_pred[7:0], exp);
      idle(2);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_out_pred", out_pred, 0);
      check_eq("rst_out_row", out_row, 0);
      check_eq("rst_out_last", out_last, 0);
      rst_n = 1'b1;
      check_eq("rst_in_ready", in_ready, 1);

      // f = 0 passes ref[i] through; check two-edge latency
      send(pack5(10, 20, 30, 40, 50), 5'd0, 1'b1);
      in_valid = 1'b0;
      check_eq("lat1_valid", out_valid, 0);
      @(posedge clk);
      #1;
      check_eq("lat2_valid", out_valid, 1);
      check_eq("f0_pred", out_pred, {8'd40, 8'd30, 8'd20, 8'd10});
      check_eq("f0_row", out_row, 0);
      idle(2);

      lane0_case("f16_lane0", 10, 21, 5'd16, 8'd16);
      lane0_case("f31_lane0", 0, 255, 5'd31, 8'd247);
      lane0_case("f1_lane0", 0, 255, 5'd1, 8'd8);

      // Backpressure: out_ready low for 5 cycles at the start of a 10-beat block
      out_ready = 1'b0;
      fork
         begin
            for (int k = 0; k < 10; k++)
               send(pack5($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                          $urandom_range(0, 255), $urandom_range(0, 255)),
                    5'($urandom_range(0, 31)), k == 9);
            in_valid = 1'b0;
         end
         begin
            repeat (5) @(posedge clk);
            #1;
            check_eq("bp_in_ready", in_ready, 0);
            check_eq("bp_buffered", 128'(sb.size()), 128'(2));
            out_ready = 1'b1;
         end
      join
      idle(4);

      // Back-to-back blocks of 3 and 2 beats
      for (int k = 0; k < 5; k++)
         send(pack5(k, k + 1, k + 2, k + 3, k + 4), 5'(k * 5), (k == 2) || (k == 4));
      in_valid = 1'b0;
      idle(4);

      // Random stream with random downstream stalls
      fork
         begin
            for (int k = 0; k < 30; k++)
               send(pack5($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                          $urandom_range(0, 255), $urandom_range(0, 255)),
                    5'($urandom_range(0, 31)), $urandom_range(0, 5) == 0);
            in_valid = 1'b0;
         end
         begin
            repeat (80) begin
               @(posedge clk);
               #1;
               out_ready = 1'($urandom_range(0, 1));
            end
            out_ready = 1'b1;
         end
      join
      idle(6);

      // Reset with both stages full
      out_ready = 1'b0;
      send(pack5(1, 2, 3, 4, 5), 5'd3, 1'b0);
      send(pack5(6, 7, 8, 9, 10), 5'd4, 1'b0);
      in_valid = 1'b0;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check_eq("mrst_out_valid", out_valid, 0);
      check_eq("mrst_out_pred", out_pred, 0);
      check_eq("mrst_in_ready", in_ready, 1);
      rst_n = 1'b1;
      out_ready = 1'b1;
      send(pack5(100, 200, 0, 0, 0), 5'd8, 1'b1);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      check_eq("mrst_valid_after", out_valid, 1);
      check_eq("mrst_row_after", out_row, 0);
      idle(4);

      check_eq("sb_drained", 128'(sb.size()), 128'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
      $finish;
   end

endmodule
